wptr_full_ctrl: RTL and testbench
=================================

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Write-side pointer and full-flag generator for the 8-entry async FIFO: produces binary/Gray write pointers and status flags in the w_clk domain.

Parameters
REQ-001 SHALL provide parameter ADDR_W, default 3, meaning memory address width; pointer width PW = ADDR_W+1, depth D = 2^ADDR_W.
REQ-002 SHALL provide parameter AF_LEVEL, default 6, meaning the fill level at or above which almost_full asserts; legal range 1..D.

Interface
REQ-003 w_clk  input  1  write clock; all state updates on its rising edge.
REQ-004 w_rst  input  1  reset, asynchronous and active-high.
REQ-005 w_en  input  1  write request from the producer.
REQ-006 ovf_clr  input  1  clears the sticky overflow flag.
REQ-007 g_rptr  input  PW  Gray read pointer from the r_clk domain, unsynchronized.
REQ-008 b_wptr  output  PW  registered binary write pointer; low ADDR_W bits address memory.
REQ-009 g_wptr  output  PW  registered Gray write pointer, for the read domain.
REQ-010 full  output  1  registered; FIFO holds D entries.
REQ-011 almost_full  output  1  registered; w_level >= AF_LEVEL.
REQ-012 w_level  output  PW  registered fill level, 0..D.
REQ-013 overflow  output  1  sticky; a write was attempted while full.

Function
REQ-014 SHALL synchronize g_rptr through two w_clk flops (sync1, sync2) before any use; no other logic SHALL sample g_rptr.
REQ-015 SHALL convert sync2 to binary rbin_s with a Gray-to-binary XOR chain.
REQ-016 A write SHALL be accepted when w_en=1 and full=0; otherwise b_wptr and g_wptr SHALL hold.
REQ-017 On acceptance, b_wptr_next = b_wptr+1 mod 2^PW, and g_wptr_next = b_wptr_next ^ (b_wptr_next>>1); both SHALL register on the same edge.
REQ-018 w_level SHALL register (b_wptr_next - rbin_s) mod 2^PW each edge.
REQ-019 full SHALL register (g_wptr_next == {~sync2[PW-1:PW-2], sync2[PW-3:0]}).
REQ-020 Invariant: full == (w_level == D) on every cycle.
REQ-021 almost_full SHALL register (w_level_next >= AF_LEVEL).
REQ-022 Latency: after a write accepted at edge N, b_wptr, g_wptr, w_level and full SHALL update at edge N.
REQ-023 Latency: after a g_rptr change settles before edge N, sync2 SHALL update at edge N+1 and w_level, full and almost_full at edge N+2.
REQ-024 Flags SHALL be pessimistic: a stale read pointer may overstate level or full, and SHALL never understate either.
REQ-025 Wrap-around: the pointer SHALL roll from 2^PW-1 to 0 with no glitch or skipped value; g_wptr SHALL change exactly one bit per increment.
REQ-026 A write accepted in the same cycle as a read-pointer advance SHALL yield the combined level, with no lost update.
REQ-027 overflow SHALL set on any edge with w_en=1 and full=1, clear on ovf_clr=1, and set SHALL win when both occur in the same cycle.

Reset
REQ-028 On w_rst=1, without waiting for a clock edge, these SHALL go to 0: sync1, sync2, b_wptr, g_wptr, w_level, full, almost_full, overflow.
REQ-029 While w_rst=1, writes SHALL be ignored.
REQ-030 Reset mid-operation SHALL discard the pointer state; the read side is reset by its own domain.
REQ-031 The first accepted write after w_rst deasserts SHALL target address 0.

Verification
REQ-032 Reset: assert w_rst asynchronously between edges -> all outputs 0 immediately; release, then one write -> b_wptr=0001, g_wptr=0001, w_level=1.
REQ-033 Fill: g_rptr=0000, 8 consecutive writes -> after the 6th, almost_full=1 and w_level=6; after the 8th, full=1, b_wptr=1000, g_wptr=1100, w_level=8.
REQ-034 Overflow: while full, pulse w_en once -> b_wptr holds 1000 and overflow=1; then ovf_clr=1 together with w_en=1 -> overflow remains 1; then ovf_clr alone -> overflow=0.
REQ-035 Drain via read pointer: full state, g_rptr changed to 0010 (binary 3) before edge N -> full=1 at edges N and N+1; at edge N+2, full=0, w_level=5, almost_full=0.
REQ-036 Wrap: drive the pointers around twice with g_rptr tracking -> b_wptr rolls 1111->0000, g_wptr 1000->0000, exactly one Gray bit per step, no false full.
REQ-037 Simultaneous: w_level=4, one accepted write in the cycle the synced read pointer advances by 1 -> w_level remains 4.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// ============================================================================
// wptr_full_ctrl
// ----------------------------------------------------------------------------
// Write-side pointer and status generator for an async FIFO. Everything here
// lives in the w_clk domain. The Gray read pointer arriving from the read
// domain passes through a two-flop synchronizer before any other logic uses it.
// The write pointers and the level, full and almost_full flags are all
// registered.
//
// Ports
//   w_clk       in   1   write clock; all state changes on its rising edge
//   w_rst       in   1   asynchronous, active-high reset
//   w_en        in   1   write request from the producer
//   ovf_clr     in   1   clears the sticky overflow flag
//   g_rptr      in   PW  Gray read pointer from the r_clk domain (unsynchronized)
//   b_wptr      out  PW  binary write pointer; low ADDR_W bits address memory
//   g_wptr      out  PW  Gray write pointer, handed to the read domain
//   full        out  1   FIFO holds D entries
//   almost_full out  1   w_level >= AF_LEVEL
//   w_level     out  PW  fill level as seen from the write side, 0..D
//   overflow    out  1   sticky: a write was attempted while full
//
// Handshake: w_en is the producer's valid and ~full is the ready. A write
// transfers on a rising w_clk edge where w_en=1 and full=0. A w_en held
// while full is not transferred; it is recorded in the overflow flag.
//
// ADDR_W must be at least 2. The full compare inverts the top two Gray bits.
// ============================================================================
module wptr_full_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_en,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   g_rptr,
    output logic [ADDR_W:0]   b_wptr,
    output logic [ADDR_W:0]   g_wptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   w_level,
    output logic              overflow
);

    localparam int PW = ADDR_W + 1;

    // AF_LEVEL is at most D = 2^ADDR_W, so it always fits in PW bits.
    localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);

    // ------------------------------------------------------------------------
    // Gray <-> binary helpers
    // ------------------------------------------------------------------------
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // MSB passes through unchanged. Each lower bit is the XOR of itself
    // with every Gray bit above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------------
    // Read-pointer synchronizer
    // ------------------------------------------------------------------------
    // g_rptr is sampled only here. A Gray code changes at most one bit per
    // step, so a metastable sample can only resolve to the old or the new
    // pointer. Either value is safe: an old read pointer can only overstate
    // the level.
    logic [PW-1:0] sync1;
    logic [PW-1:0] sync2;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= g_rptr;
            sync2 <= sync1;
        end
    end

    logic [PW-1:0] rbin_s;
    assign rbin_s = gray2bin(sync2);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic          wr_accept;
    logic [PW-1:0] b_wptr_next;
    logic [PW-1:0] g_wptr_next;
    logic [PW-1:0] w_level_next;
    logic          full_next;
    logic          almost_full_next;
    logic          overflow_next;
    logic [PW-1:0] full_gray;

    always_comb begin
        wr_accept        = 1'b0;
        b_wptr_next      = b_wptr;
        g_wptr_next      = g_wptr;
        w_level_next     = w_level;
        full_next        = full;
        almost_full_next = almost_full;
        overflow_next    = overflow;
        full_gray        = '0;

        wr_accept   = w_en & ~full;
        b_wptr_next = b_wptr + {{(PW-1){1'b0}}, wr_accept};
        g_wptr_next = bin2gray(b_wptr_next);

        // The level uses the pointer after this cycle's write. A write and a
        // read-pointer step in the same cycle therefore combine into one
        // result, and neither update is lost.
        w_level_next = b_wptr_next - rbin_s;

        // The write side is exactly one lap ahead of the read side. In Gray
        // code that means the top two bits are inverted and the rest match.
        full_gray = {~sync2[PW-1:PW-2], sync2[PW-3:0]};
        full_next = (g_wptr_next == full_gray);

        almost_full_next = (w_level_next >= AF_LVL);

        // Set has priority over clear, so an attempt in the same cycle as a
        // clear is never lost.
        if (w_en && full) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end else begin
            overflow_next = overflow;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // While w_rst is high these registers are held at zero, so a w_en that
    // arrives during reset has no effect.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            w_level     <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_wptr_next;
            g_wptr      <= g_wptr_next;
            w_level     <= w_level_next;
            full        <= full_next;
            almost_full <= almost_full_next;
            overflow    <= overflow_next;
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// ============================================================================
// tb_wptr_full_ctrl
// ----------------------------------------------------------------------------
// Directed bench for wptr_full_ctrl with the default parameters (ADDR_W=3,
// AF_LEVEL=6). Inputs change 1 ns after the rising edge, and outputs are
// sampled at the same point. Expected values are worked out by hand from the
// pointer arithmetic.
// ============================================================================
module tb_wptr_full_ctrl;

    localparam int ADDR_W = 3;
    localparam int PW     = ADDR_W + 1;

    logic          w_clk;
    logic          w_rst;
    logic          w_en;
    logic          ovf_clr;
    logic [PW-1:0] g_rptr;
    logic [PW-1:0] b_wptr;
    logic [PW-1:0] g_wptr;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] w_level;
    logic          overflow;

    int num_checks;
    int num_fail;

    wptr_full_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(6)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_en        (w_en),
        .ovf_clr     (ovf_clr),
        .g_rptr      (g_rptr),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .overflow    (overflow)
    );

    // ---------------- clock ----------------
    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // ---------------- driver tasks ----------------
    // Advance one rising edge and land 1 ns after it.
    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    // One clock cycle with w_en set to en; w_en is dropped afterwards.
    task automatic write_cycle(input logic en);
        w_en = en;
        step();
        w_en = 1'b0;
    endtask

    task automatic apply_reset();
        w_rst   = 1'b1;
        w_en    = 1'b0;
        ovf_clr = 1'b0;
        g_rptr  = '0;
        step();
        w_rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) write_cycle(1'b1);
        num_checks++;
        if (b_wptr !== 4'd3) begin
            num_fail++;
            $display("FAIL pre_reset_b_wptr: got %b expected %b", b_wptr, 4'd3);
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #3;
        w_rst = 1'b1;
        #1;
        num_checks++;
        if ({b_wptr, g_wptr, w_level, full, almost_full, overflow} !== '0) begin
            num_fail++;
            $display("FAIL async_reset: got b=%b g=%b lvl=%b f=%b af=%b ovf=%b expected all zero",
                     b_wptr, g_wptr, w_level, full, almost_full, overflow);
        end
        // A write requested while reset is held must be ignored.
        w_en = 1'b1;
        step();
        step();
        w_en = 1'b0;
        num_checks++;
        if (b_wptr !== 4'd0) begin
            num_fail++;
            $display("FAIL write_during_reset: got %b expected %b", b_wptr, 4'd0);
        end
        w_rst = 1'b0;
        write_cycle(1'b1);
        num_checks++;
        if (b_wptr !== 4'b0001 || g_wptr !== 4'b0001 || w_level !== 4'd1 || full !== 1'b0) begin
            num_fail++;
            $display("FAIL first_write: got b=%b g=%b lvl=%0d f=%b expected b=0001 g=0001 lvl=1 f=0",
                     b_wptr, g_wptr, w_level, full);
        end
    endtask

    task automatic test_fill();
        logic [PW-1:0] exp_g;
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            write_cycle(1'b1);
            exp_g = 4'(i ^ (i >> 1));
            num_checks++;
            if (w_level !== 4'(i) || almost_full !== (i >= 6) || full !== (i == 8)
                || b_wptr !== 4'(i) || g_wptr !== exp_g) begin
                num_fail++;
                $display("FAIL fill_%0d: got b=%b g=%b lvl=%0d af=%b f=%b expected b=%b g=%b lvl=%0d af=%b f=%b",
                         i, b_wptr, g_wptr, w_level, almost_full, full,
                         4'(i), exp_g, i, (i >= 6), (i == 8));
            end
        end
        num_checks++;
        if (b_wptr !== 4'b1000 || g_wptr !== 4'b1100 || full !== 1'b1) begin
            num_fail++;
            $display("FAIL fill_final: got b=%b g=%b f=%b expected b=1000 g=1100 f=1",
                     b_wptr, g_wptr, full);
        end
    endtask

    // Starts from the full state left by test_fill.
    task automatic test_overflow();
        num_checks++;
        if (overflow !== 1'b0) begin
            num_fail++;
            $display("FAIL ovf_initial: got %b expected 0", overflow);
        end
        write_cycle(1'b1);
        num_checks++;
        if (b_wptr !== 4'b1000 || overflow !== 1'b1 || full !== 1'b1) begin
            num_fail++;
            $display("FAIL ovf_set: got b=%b ovf=%b f=%b expected b=1000 ovf=1 f=1",
                     b_wptr, overflow, full);
        end
        ovf_clr = 1'b1;
        write_cycle(1'b1);
        ovf_clr = 1'b0;
        num_checks++;
        if (overflow !== 1'b1) begin
            num_fail++;
            $display("FAIL ovf_set_wins: got %b expected 1", overflow);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        num_checks++;
        if (overflow !== 1'b0) begin
            num_fail++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        step();
        num_checks++;
        if (overflow !== 1'b0 || b_wptr !== 4'b1000) begin
            num_fail++;
            $display("FAIL ovf_stays_clear: got ovf=%b b=%b expected ovf=0 b=1000", overflow, b_wptr);
        end
    endtask

    // Starts from the full state. The read pointer moves to Gray 0010 (binary 3).
    task automatic test_drain();
        g_rptr = 4'b0010;
        step(); // edge N
        num_checks++;
        if (full !== 1'b1 || w_level !== 4'd8) begin
            num_fail++;
            $display("FAIL drain_edge_n: got f=%b lvl=%0d expected f=1 lvl=8", full, w_level);
        end
        step(); // edge N+1
        num_checks++;
        if (full !== 1'b1 || w_level !== 4'd8) begin
            num_fail++;
            $display("FAIL drain_edge_n1: got f=%b lvl=%0d expected f=1 lvl=8", full, w_level);
        end
        step(); // edge N+2
        num_checks++;
        if (full !== 1'b0 || w_level !== 4'd5 || almost_full !== 1'b0) begin
            num_fail++;
            $display("FAIL drain_edge_n2: got f=%b lvl=%0d af=%b expected f=0 lvl=5 af=0",
                     full, w_level, almost_full);
        end
    endtask

    // Two full laps of the pointer. The read pointer trails two entries
    // behind, so the FIFO never fills.
    task automatic test_wrap();
        logic [PW-1:0] prev_g;
        logic [PW-1:0] exp_b;
        logic [PW-1:0] exp_g;
        logic [PW-1:0] rd;
        apply_reset();
        exp_b = '0;
        for (int k = 0; k < 34; k++) begin
            prev_g = g_wptr;
            write_cycle(1'b1);
            exp_b = exp_b + 4'd1;
            exp_g = exp_b ^ (exp_b >> 1);
            num_checks++;
            if (b_wptr !== exp_b || g_wptr !== exp_g) begin
                num_fail++;
                $display("FAIL wrap_ptr_%0d: got b=%b g=%b expected b=%b g=%b",
                         k, b_wptr, g_wptr, exp_b, exp_g);
            end
            num_checks++;
            if ($countones(g_wptr ^ prev_g) != 1) begin
                num_fail++;
                $display("FAIL wrap_gray_step_%0d: got %b -> %b expected one bit change",
                         k, prev_g, g_wptr);
            end
            num_checks++;
            if (full !== 1'b0) begin
                num_fail++;
                $display("FAIL wrap_false_full_%0d: got f=%b expected 0", k, full);
            end
            if (exp_b >= 4'd2 || k >= 2) begin
                rd     = exp_b - 4'd2;
                g_rptr = rd ^ (rd >> 1);
            end
        end
    endtask

    // Level 4. One write lands on the same edge that the synchronized read
    // pointer advances by one.
    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 4; i++) write_cycle(1'b1);
        step();
        step();
        num_checks++;
        if (w_level !== 4'd4) begin
            num_fail++;
            $display("FAIL simul_setup: got lvl=%0d expected 4", w_level);
        end
        g_rptr = 4'b0001;
        step(); // N: sync1 captures
        step(); // N+1: sync2 captures; the level still uses the old sync2
        num_checks++;
        if (w_level !== 4'd4) begin
            num_fail++;
            $display("FAIL simul_before: got lvl=%0d expected 4", w_level);
        end
        write_cycle(1'b1); // N+2: write and read advance combine
        num_checks++;
        if (w_level !== 4'd4 || b_wptr !== 4'd5) begin
            num_fail++;
            $display("FAIL simul_combined: got lvl=%0d b=%b expected lvl=4 b=0101", w_level, b_wptr);
        end
        step();
        num_checks++;
        if (w_level !== 4'd4) begin
            num_fail++;
            $display("FAIL simul_after: got lvl=%0d expected 4", w_level);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        num_checks = 0;
        num_fail   = 0;
        w_rst      = 1'b1;
        w_en       = 1'b0;
        ovf_clr    = 1'b0;
        g_rptr     = '0;
        #2;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
